pc_unit_ras: RTL and testbench
==============================

Name: pc_unit_ras

Overview:
- Parametrised next-generation program counter for the fetch stage.
- Holds the current fetch PC and selects the next PC: hold, sequential, PC-relative branch or absolute jump.
- Adds a stall input and a circular return-address stack (RAS) for call/return.
- Drives the instruction-memory address and the PC+INC link value used by the register writeback path.

Parameters:
- WIDTH, 64, PC / address width in bits.
- INC, 4, sequential increment in bytes; power of 2, ≥1.
- OFF_W, 26, width of the signed branch offset input.
- OFF_SHIFT, 2, left shift applied to the offset (instruction-granule scaling).
- RAS_DEPTH, 8, RAS entries; power of 2, ≥2.
- RESET_VECTOR, 64'h0, PC value loaded on reset; truncated to WIDTH.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  when 1, freeze all state.
- ps  in  2  PC select: 00 hold, 01 sequential, 10 relative, 11 absolute.
- pc_in  in  WIDTH  absolute jump target.
- offset  in  OFF_W  signed branch offset, two's complement.
- call  in  1  push link on a taken ps=10/11 transfer.
- ret  in  1  return: next PC = RAS top; overrides ps.
- pc_out  out  WIDTH  current PC (registered).
- pc_plus  out  WIDTH  pc_out+INC, combinational, modulo 2^WIDTH.
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries.
- ras_empty  out  1  ras_count==0.
- ras_full  out  1  ras_count==RAS_DEPTH.
- ras_ovf  out  1  one-cycle pulse: push while full.
- ras_unf  out  1  one-cycle pulse: ret while empty.
- misalign  out  1  see Optional Feature.

Behaviour:
- Reset, async assert, any time including mid-transfer:
  - pc_out=RESET_VECTOR.
  - RAS pointer and count = 0; RAS contents don't-care.
  - ras_ovf, ras_unf and misalign = 0.
- Next PC is latched one cycle after the inputs are presented; pc_plus tracks pc_out with no added latency.
- Next-PC priority:
  1. stall=1: everything holds; pulses drop to 0; call and ret are ignored.
  2. ret=1 and RAS non-empty: next = top; pop (count-1).
  3. ret=1 and RAS empty: next = pc_plus; ras_unf=1; count stays 0.
  4. ps=00: hold.
  5. ps=01: pc_plus.
  6. ps=10: pc_out + (sign_extend(offset) << OFF_SHIFT), truncated to WIDTH; wrap-around is legal.
  7. ps=11: pc_in.
- Push: call=1, ret=0, ps∈{10,11}, not stalled → push pc_plus (the link of the current PC). call with ps∈{00,01} is ignored.
- Push when full: circular overwrite of the oldest entry; count stays at RAS_DEPTH; ras_ovf=1 for one cycle.
- call=1 and ret=1 together, RAS non-empty: next = top; top entry replaced by pc_plus; count unchanged (coroutine swap).
- call=1 and ret=1 together, RAS empty: handled as rule 3; no push.
- The pointer wraps modulo RAS_DEPTH. After overflow, pops return the newest RAS_DEPTH entries in LIFO order.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - If a selected next PC (relative, absolute or RAS) has any of bits [log2(INC)-1:0] nonzero, those bits are cleared before latching.
  - misalign pulses 1 for that cycle.
  - Not applied under stall.
- Undefined: no alignment logic; targets latch unmodified; misalign is tied to 0.

Test Plan:
- Reset held with ps=01, then released → pc_out=0 while reset; after release, 4 clocks give pc_out 0,4,8,12; pc_plus=pc_out+4 throughout.
- pc_out=0x100, ps=10, offset=-4 → pc_out=0x0F0. Then pc_out=0xFFFF_FFFF_FFFF_FFFC, ps=01 → wraps to 0.
- pc_out=0x40, ps=11, pc_in=0x2000, call=1 → pc_out=0x2000, RAS top=0x44, count=1. Next cycle ret=1 → pc_out=0x44, count=0, ras_empty=1.
- RAS_DEPTH=8, 9 consecutive calls with links L1..L9 → ras_ovf pulses on the 9th call; count=8. Then 8 rets yield L9..L2; a 9th ret gives ras_unf=1 and pc_out=pc_plus.
- stall=1 during ps=11, call=1 → pc_out, RAS and count unchanged; no pulses.
- PC_ALIGN_CHECK_EN defined, ps=11, pc_in=0x1003 → pc_out=0x1000, misalign=1 for one cycle. Undefined → pc_out=0x1003, misalign=0.

Source files
------------

// File: rtl/pc_unit_ras.sv
// pc_unit_ras -- fetch-stage program counter with a circular return-address stack.
//
// Holds the current fetch PC and picks the next one: hold, sequential (+INC),
// PC-relative branch, absolute jump, or a return taken from the RAS. Calls on a
// taken relative/absolute transfer push the link (pc_out+INC) onto the RAS.
//
// Optional build macro: PC_ALIGN_CHECK_EN
//   defined   -> relative/absolute/RAS targets have their low log2(INC) bits
//                cleared before latching, and misalign pulses for that cycle.
//   undefined -> targets latch unmodified, misalign is tied to 0.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset
//   stall      freeze all state; pulses drop, call/ret ignored
//   ps         PC select: 00 hold, 01 sequential, 10 relative, 11 absolute
//   pc_in      absolute jump target
//   offset     signed branch offset (scaled by OFF_SHIFT)
//   call       push link on a taken ps=10/11 transfer
//   ret        return to RAS top; overrides ps
//   pc_out     current PC (registered)
//   pc_plus    pc_out + INC (combinational, wraps)
//   ras_count  number of valid RAS entries
//   ras_empty  ras_count == 0
//   ras_full   ras_count == RAS_DEPTH
//   ras_ovf    one-cycle pulse: push while full
//   ras_unf    one-cycle pulse: ret while empty
//   misalign   one-cycle pulse: a target was realigned (macro builds only)
module pc_unit_ras #(
  parameter int          WIDTH        = 64,
  parameter int          INC          = 4,
  parameter int          OFF_W        = 26,
  parameter int          OFF_SHIFT    = 2,
  parameter int          RAS_DEPTH    = 8,
  parameter logic [63:0] RESET_VECTOR = 64'h0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [1:0]                     ps,
  input  logic [WIDTH-1:0]               pc_in,
  input  logic [OFF_W-1:0]               offset,
  input  logic                           call,
  input  logic                           ret,
  output logic [WIDTH-1:0]               pc_out,
  output logic [WIDTH-1:0]               pc_plus,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_ovf,
  output logic                           ras_unf,
  output logic                           misalign
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_r;      // next free slot; top is ptr_r-1
  logic [CNT_W-1:0] count_r;
  logic             empty_r;
  logic             full_r;
  logic             ovf_r;
  logic             unf_r;

  logic [WIDTH-1:0] pc_plus_s;
  logic signed [WIDTH-1:0] off_ext_s;
  logic [WIDTH-1:0] off_scaled_s;
  logic [PTR_W-1:0] top_idx_s;
  logic [WIDTH-1:0] pc_sel_s;   // selected next PC before any realignment
  logic [WIDTH-1:0] pc_next_s;
  logic             push_s;
  logic             pop_s;
  logic             swap_s;
  logic             ovf_next_s;
  logic             unf_next_s;
  logic [PTR_W-1:0] ptr_next_s;
  logic [CNT_W-1:0] count_next_s;

  assign pc_plus_s    = pc_r + WIDTH'(INC);
  assign off_ext_s    = WIDTH'($signed(offset));
  assign off_scaled_s = off_ext_s <<< OFF_SHIFT;
  assign top_idx_s    = ptr_r - PTR_W'(1);

  // Next-PC priority and RAS operation decode.
  always_comb begin
    pc_sel_s   = pc_r;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    swap_s     = 1'b0;
    unf_next_s = 1'b0;
    if (stall) begin
      pc_sel_s = pc_r;
    end else if (ret) begin
      if (count_r != CNT_W'(0)) begin
        pc_sel_s = ras_mem_r[top_idx_s];
        // call+ret on a non-empty stack replaces the top instead of popping
        if (call) begin
          swap_s = 1'b1;
        end else begin
          pop_s = 1'b1;
        end
      end else begin
        pc_sel_s   = pc_plus_s;
        unf_next_s = 1'b1;
      end
    end else begin
      case (ps)
        2'b00: pc_sel_s = pc_r;
        2'b01: pc_sel_s = pc_plus_s;
        2'b10: begin
          pc_sel_s = pc_r + off_scaled_s;
          push_s   = call;
        end
        2'b11: begin
          pc_sel_s = pc_in;
          push_s   = call;
        end
        default: pc_sel_s = pc_r;
      endcase
    end
  end

  assign ovf_next_s = push_s & full_r;

  // Pointer and occupancy update; a push while full overwrites the oldest slot.
  always_comb begin
    ptr_next_s   = ptr_r;
    count_next_s = count_r;
    if (push_s) begin
      ptr_next_s = ptr_r + PTR_W'(1);
      if (full_r) begin
        count_next_s = count_r;
      end else begin
        count_next_s = count_r + CNT_W'(1);
      end
    end else if (pop_s) begin
      ptr_next_s   = top_idx_s;
      count_next_s = count_r - CNT_W'(1);
    end else begin
      ptr_next_s   = ptr_r;
      count_next_s = count_r;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

  logic target_chk_s;
  logic mis_next_s;
  logic mis_r;

  // Only redirected targets are checked; sequential and hold paths stay aligned.
  assign target_chk_s = !stall && ((ret && (count_r != CNT_W'(0))) || (!ret && ps[1]));

  // Clear low bits of a misaligned target and flag it.
  always_comb begin
    pc_next_s  = pc_sel_s;
    mis_next_s = 1'b0;
    if (target_chk_s && ((pc_sel_s & ALIGN_MASK) != '0)) begin
      pc_next_s  = pc_sel_s & ~ALIGN_MASK;
      mis_next_s = 1'b1;
    end else begin
      pc_next_s  = pc_sel_s;
      mis_next_s = 1'b0;
    end
  end

  // Misalign pulse register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mis_r <= 1'b0;
    end else begin
      mis_r <= mis_next_s;
    end
  end

  assign misalign = mis_r;
`else
  assign pc_next_s = pc_sel_s;
  assign misalign  = 1'b0;
`endif

  // PC, pointer, occupancy flags and event pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_r    <= WIDTH'(RESET_VECTOR);
      ptr_r   <= '0;
      count_r <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      pc_r    <= pc_next_s;
      ptr_r   <= ptr_next_s;
      count_r <= count_next_s;
      empty_r <= (count_next_s == CNT_W'(0));
      full_r  <= (count_next_s == CNT_W'(RAS_DEPTH));
      ovf_r   <= ovf_next_s;
      unf_r   <= unf_next_s;
    end
  end

  // RAS storage: push writes the free slot, swap rewrites the top.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= '0;
      end
    end else if (push_s) begin
      ras_mem_r[ptr_r] <= pc_plus_s;
    end else if (swap_s) begin
      ras_mem_r[top_idx_s] <= pc_plus_s;
    end
  end

  assign pc_out    = pc_r;
  assign pc_plus   = pc_plus_s;
  assign ras_count = count_r;
  assign ras_empty = empty_r;
  assign ras_full  = full_r;
  assign ras_ovf   = ovf_r;
  assign ras_unf   = unf_r;

endmodule

// File: tb/tb_pc_unit_ras.sv
module tb_pc_unit_ras;

  typedef struct {
    logic [63:0] pc;
    int          cnt;
    logic        ovf;
    logic        unf;
    logic        mis;
    string       tag;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  ps = 2'b00;
  logic [63:0] pc_in = 64'h0;
  logic [25:0] offset = 26'h0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [63:0] pc_out;
  logic [63:0] pc_plus;
  logic [3:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_unf;
  logic        misalign;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  exp_t cur;

  pc_unit_ras dut (
    .clock(clock), .reset(reset), .stall(stall), .ps(ps), .pc_in(pc_in),
    .offset(offset), .call(call), .ret(ret), .pc_out(pc_out), .pc_plus(pc_plus),
    .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf), .misalign(misalign)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] pc, input int cnt, input logic ovf,
                              input logic unf, input logic mis, input string tag);
    exp_t e;
    e.pc = pc; e.cnt = cnt; e.ovf = ovf; e.unf = unf; e.mis = mis; e.tag = tag;
    return e;
  endfunction

  // Apply one cycle of inputs; the expectation becomes due after the capturing edge.
  task automatic step(input logic st, input logic [1:0] p, input logic [63:0] pi,
                      input logic [25:0] off, input logic c, input logic r, input exp_t e);
    stall = st; ps = p; pc_in = pi; offset = off; call = c; ret = r;
    @(posedge clock);
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: compare DUT state against the oldest pending expectation.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk({cur.tag, ".pc_out"},    pc_out,    cur.pc);
      chk({cur.tag, ".pc_plus"},   pc_plus,   cur.pc + 64'd4);
      chk({cur.tag, ".ras_count"}, 64'(ras_count), 64'(cur.cnt));
      chk({cur.tag, ".ras_empty"}, 64'(ras_empty), 64'(cur.cnt == 0));
      chk({cur.tag, ".ras_full"},  64'(ras_full),  64'(cur.cnt == 8));
      chk({cur.tag, ".ras_ovf"},   64'(ras_ovf),   64'(cur.ovf));
      chk({cur.tag, ".ras_unf"},   64'(ras_unf),   64'(cur.unf));
      chk({cur.tag, ".misalign"},  64'(misalign),  64'(cur.mis));
    end
  end

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    #2 reset = 1'b1;
    // Reset held with ps=01: PC stays at the reset vector.
    for (int i = 0; i < 3; i++) step(1'b0, 2'b01, 64'h0, 26'h0, 1'b0, 1'b0, mk(64'h0, 0, 1'b0, 1'b0, 1'b0, "rst_hold"));
    reset = 1'b0;
    step(1'b0, 2'b01, 64'h0, 26'h0, 1'b0, 1'b0, mk(64'h4, 0, 1'b0, 1'b0, 1'b0, "seq1"));
    step(1'b0, 2'b01, 64'h0, 26'h0, 1'b0, 1'b0, mk(64'h8, 0, 1'b0, 1'b0, 1'b0, "seq2"));
    step(1'b0, 2'b01, 64'h0, 26'h0, 1'b0, 1'b0, mk(64'hC, 0, 1'b0, 1'b0, 1'b0, "seq3"));
    // Relative branch with negative offset, then wrap-around cases.
    step(1'b0, 2'b11, 64'h100, 26'h0, 1'b0, 1'b0, mk(64'h100, 0, 1'b0, 1'b0, 1'b0, "abs100"));
    step(1'b0, 2'b10, 64'h0, 26'h3FF_FFFC, 1'b0, 1'b0, mk(64'hF0, 0, 1'b0, 1'b0, 1'b0, "rel_m4"));
    step(1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFC, 26'h0, 1'b0, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFC, 0, 1'b0, 1'b0, 1'b0, "abs_top"));
    step(1'b0, 2'b01, 64'h0, 26'h0, 1'b0, 1'b0, mk(64'h0, 0, 1'b0, 1'b0, 1'b0, "seq_wrap"));
    step(1'b0, 2'b10, 64'h0, 26'h3FF_FFFF, 1'b0, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFC, 0, 1'b0, 1'b0, 1'b0, "rel_wrap_dn"));
    step(1'b0, 2'b10, 64'h0, 26'h000_0001, 1'b0, 1'b0, mk(64'h0, 0, 1'b0, 1'b0, 1'b0, "rel_wrap_up"));
    step(1'b0, 2'b00, 64'h0, 26'h0, 1'b0, 1'b0, mk(64'h0, 0, 1'b0, 1'b0, 1'b0, "hold"));
    // Single call and return.
    step(1'b0, 2'b11, 64'h40, 26'h0, 1'b0, 1'b0, mk(64'h40, 0, 1'b0, 1'b0, 1'b0, "abs40"));
    step(1'b0, 2'b11, 64'h2000, 26'h0, 1'b1, 1'b0, mk(64'h2000, 1, 1'b0, 1'b0, 1'b0, "call1"));
    step(1'b0, 2'b01, 64'h0, 26'h0, 1'b0, 1'b1, mk(64'h44, 0, 1'b0, 1'b0, 1'b0, "ret1"));
    // Nine calls from 0x44: links 0x48, 0x1004..0x8004; ninth overwrites 0x48.
    for (int k = 1; k <= 9; k++)
      step(1'b0, 2'b11, 64'(k) * 64'h1000, 26'h0, 1'b1, 1'b0,
           mk(64'(k) * 64'h1000, (k > 8) ? 8 : k, (k == 9), 1'b0, 1'b0, "call9"));
    for (int j = 1; j <= 8; j++)
      step(1'b0, 2'b01, 64'h0, 26'h0, 1'b0, 1'b1,
           mk(64'(9 - j) * 64'h1000 + 64'h4, 8 - j, 1'b0, 1'b0, 1'b0, "ret8"));
    step(1'b0, 2'b01, 64'h0, 26'h0, 1'b0, 1'b1, mk(64'h1008, 0, 1'b0, 1'b1, 1'b0, "ret_unf"));
    step(1'b0, 2'b00, 64'h0, 26'h0, 1'b0, 1'b0, mk(64'h1008, 0, 1'b0, 1'b0, 1'b0, "unf_drop"));
    // Stall freezes PC and RAS even with call and ret asserted.
    step(1'b0, 2'b11, 64'h3000, 26'h0, 1'b1, 1'b0, mk(64'h3000, 1, 1'b0, 1'b0, 1'b0, "call_pre"));
    step(1'b1, 2'b11, 64'h5000, 26'h0, 1'b1, 1'b1, mk(64'h3000, 1, 1'b0, 1'b0, 1'b0, "stall"));
    // Coroutine swap: jump to 0x100C, top becomes 0x3004.
    step(1'b0, 2'b00, 64'h0, 26'h0, 1'b1, 1'b1, mk(64'h100C, 1, 1'b0, 1'b0, 1'b0, "swap"));
    step(1'b0, 2'b00, 64'h0, 26'h0, 1'b0, 1'b1, mk(64'h3004, 0, 1'b0, 1'b0, 1'b0, "swap_ret"));
    step(1'b0, 2'b00, 64'h0, 26'h0, 1'b1, 1'b1, mk(64'h3008, 0, 1'b0, 1'b1, 1'b0, "swap_empty"));
    step(1'b0, 2'b01, 64'h0, 26'h0, 1'b1, 1'b0, mk(64'h300C, 0, 1'b0, 1'b0, 1'b0, "call_seq_ign"));
    // Alignment of an absolute target.
`ifdef PC_ALIGN_CHECK_EN
    step(1'b0, 2'b11, 64'h1003, 26'h0, 1'b0, 1'b0, mk(64'h1000, 0, 1'b0, 1'b0, 1'b1, "align"));
    step(1'b0, 2'b00, 64'h0, 26'h0, 1'b0, 1'b0, mk(64'h1000, 0, 1'b0, 1'b0, 1'b0, "align_drop"));
`else
    step(1'b0, 2'b11, 64'h1003, 26'h0, 1'b0, 1'b0, mk(64'h1003, 0, 1'b0, 1'b0, 1'b0, "align"));
    step(1'b0, 2'b00, 64'h0, 26'h0, 1'b0, 1'b0, mk(64'h1003, 0, 1'b0, 1'b0, 1'b0, "align_drop"));
`endif
    // Asynchronous reset in the middle of a cycle with a live RAS entry.
    step(1'b0, 2'b11, 64'h7000, 26'h0, 1'b1, 1'b0, mk(64'h7000, 1, 1'b0, 1'b0, 1'b0, "call_pre_rst"));
    drain();
    stall = 1'b0; ps = 2'b01; call = 1'b0; ret = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_rst.pc_out", pc_out, 64'h0);
    chk("async_rst.ras_count", 64'(ras_count), 64'h0);
    chk("async_rst.ras_empty", 64'(ras_empty), 64'h1);
    @(posedge clock);
    #1 reset = 1'b0;
    step(1'b0, 2'b01, 64'h0, 26'h0, 1'b0, 1'b0, mk(64'h4, 0, 1'b0, 1'b0, 1'b0, "post_rst"));
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
